// File: rtl/pll_sup_pkg.sv
// Shared types, defaults and helpers for the PLL lock supervisor.
package pll_sup_pkg;

   typedef enum logic [1:0] {
      RESET_PLL = 2'd0,
      WAIT_LOCK = 2'd1,
      QUALIFY   = 2'd2,
      RUN       = 2'd3
   } pll_sup_state_t;

   localparam int unsigned DEF_RST_CYCLES    = 16;
   localparam int unsigned DEF_LOCK_TIMEOUT  = 50000;
   localparam int unsigned DEF_STABLE_CYCLES = 1024;
   localparam int unsigned DEF_SYNC_STAGES   = 2;
   localparam int unsigned DEF_CNT_W         = 8;

   // Increment that sticks at 2^width-1 instead of wrapping (width < 32).
   function automatic logic [31:0] sat_inc(input logic [31:0] val, input int unsigned width);
      logic [31:0] max_val;
      max_val = (32'd1 << width) - 32'd1;
      if (val >= max_val)
         sat_inc = max_val;
      else
         sat_inc = val + 32'd1;
   endfunction

endpackage

// File: rtl/sync_bit.sv
// Multi-flop synchronizer for a single asynchronous level, async active-low clear.
module sync_bit #(
   parameter int unsigned STAGES = 2
) (
   input  logic clk_i,
   input  logic rst_n_i,
   input  logic d_i,
   output logic q_o
);

   logic [STAGES-1:0] sync_q;

   // Shift the raw level through the chain; the last flop is the usable copy.
   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i)
         sync_q <= '0;
      else
         sync_q <= {sync_q[STAGES-2:0], d_i};
   end

   assign q_o = sync_q[STAGES-1];

endmodule

// File: rtl/pll_lock_supervisor.sv
// PLL reset / lock supervisor running on the free-running reference clock.
// Optional feature macro: PLL_SUP_LOSS_CNT_EN (adds the lock-loss counter;
// without it loss_cnt is tied to zero).
//
// state     | meaning
// ----------+-------------------------------------------------------------
// RESET_PLL | pll_rst held high for RST_CYCLES, downstream held in reset
// WAIT_LOCK | pll_rst released, waiting up to LOCK_TIMEOUT for lock
// QUALIFY   | lock seen, must stay high STABLE_CYCLES consecutive cycles
// RUN       | downstream reset released, ready high, watching for loss
module pll_lock_supervisor
   import pll_sup_pkg::*;
#(
   parameter int unsigned RST_CYCLES    = DEF_RST_CYCLES,
   parameter int unsigned LOCK_TIMEOUT  = DEF_LOCK_TIMEOUT,
   parameter int unsigned STABLE_CYCLES = DEF_STABLE_CYCLES,
   parameter int unsigned SYNC_STAGES   = DEF_SYNC_STAGES,
   parameter int unsigned CNT_W         = DEF_CNT_W
) (
   input  logic             refclk,
   input  logic             rst_n,
   input  logic             pll_locked,
   output logic             pll_rst,
   output logic             sys_rst_n,
   output logic             ready,
   output logic [1:0]       state,
   output logic [CNT_W-1:0] retry_cnt,
   output logic [CNT_W-1:0] loss_cnt
);

   localparam int unsigned TMR_MAX =
      (RST_CYCLES > LOCK_TIMEOUT)
         ? ((RST_CYCLES > STABLE_CYCLES) ? RST_CYCLES : STABLE_CYCLES)
         : ((LOCK_TIMEOUT > STABLE_CYCLES) ? LOCK_TIMEOUT : STABLE_CYCLES);
   localparam int unsigned TMR_W = $clog2(TMR_MAX + 1);

   localparam logic [TMR_W-1:0] TMR_RST = TMR_W'(RST_CYCLES);
   localparam logic [TMR_W-1:0] TMR_TO  = TMR_W'(LOCK_TIMEOUT);
   localparam logic [TMR_W-1:0] TMR_STB = TMR_W'(STABLE_CYCLES);
   localparam logic [TMR_W-1:0] TMR_ONE = TMR_W'(1);

   pll_sup_state_t   state_q, state_d;
   logic [TMR_W-1:0] tmr_q, tmr_d;
   logic             tmr_exp;
   logic             lk;
   logic             retry_inc;
   logic [CNT_W-1:0] retry_q, retry_d;
   logic             pll_rst_q, sys_rst_n_q, ready_q;

   sync_bit #(
      .STAGES (SYNC_STAGES)
   ) u_sync_locked (
      .clk_i   (refclk),
      .rst_n_i (rst_n),
      .d_i     (pll_locked),
      .q_o     (lk)
   );

   // A load of N expires on the Nth cycle in the state; zero is treated as expired too.
   assign tmr_exp = (tmr_q <= TMR_ONE);

   // Next state and timer reload; lock is tested before timeout so lock wins a tie.
   always_comb begin
      state_d   = state_q;
      tmr_d     = tmr_q;
      retry_inc = 1'b0;
      case (state_q)
         RESET_PLL: begin
            if (tmr_exp) begin
               state_d = WAIT_LOCK;
               tmr_d   = TMR_TO;
            end else begin
               tmr_d = tmr_q - TMR_ONE;
            end
         end
         WAIT_LOCK: begin
            if (lk) begin
               state_d = QUALIFY;
               tmr_d   = TMR_STB;
            end else if (tmr_exp) begin
               state_d   = RESET_PLL;
               tmr_d     = TMR_RST;
               retry_inc = 1'b1;
            end else begin
               tmr_d = tmr_q - TMR_ONE;
            end
         end
         QUALIFY: begin
            if (!lk) begin
               state_d = WAIT_LOCK;
               tmr_d   = TMR_TO;
            end else if (tmr_exp) begin
               state_d = RUN;
               tmr_d   = '0;
            end else begin
               tmr_d = tmr_q - TMR_ONE;
            end
         end
         RUN: begin
            if (!lk) begin
               state_d = RESET_PLL;
               tmr_d   = TMR_RST;
            end
         end
         default: begin
            state_d = RESET_PLL;
            tmr_d   = TMR_RST;
         end
      endcase
   end

   // State, timer and registered outputs (outputs decoded from the next state).
   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n) begin
         state_q     <= RESET_PLL;
         tmr_q       <= TMR_RST;
         pll_rst_q   <= 1'b1;
         sys_rst_n_q <= 1'b0;
         ready_q     <= 1'b0;
      end else begin
         state_q     <= state_d;
         tmr_q       <= tmr_d;
         pll_rst_q   <= (state_d == RESET_PLL);
         sys_rst_n_q <= (state_d == RUN);
         ready_q     <= (state_d == RUN);
      end
   end

   assign retry_d = retry_inc ? CNT_W'(sat_inc(32'(retry_q), CNT_W)) : retry_q;

   // Lock-timeout counter, cleared only by rst_n.
   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n)
         retry_q <= '0;
      else
         retry_q <= retry_d;
   end

`ifdef PLL_SUP_LOSS_CNT_EN
   logic             loss_inc;
   logic [CNT_W-1:0] loss_q, loss_d;

   assign loss_inc = (state_q == RUN) && !lk;
   assign loss_d   = loss_inc ? CNT_W'(sat_inc(32'(loss_q), CNT_W)) : loss_q;

   // Lock-loss-in-RUN counter, cleared only by rst_n.
   always_ff @(posedge refclk or negedge rst_n) begin
      if (!rst_n)
         loss_q <= '0;
      else
         loss_q <= loss_d;
   end

   assign loss_cnt = loss_q;
`else
   assign loss_cnt = '0;
`endif

   assign pll_rst   = pll_rst_q;
   assign sys_rst_n = sys_rst_n_q;
   assign ready     = ready_q;
   assign state     = state_q;
   assign retry_cnt = retry_q;

endmodule

// File: tb/tb_pll_lock_supervisor.sv
// Randomized + directed bench for pll_lock_supervisor against a behavioural model.
module tb_pll_lock_supervisor;

   localparam int RST = 4;
   localparam int TO  = 20;
   localparam int ST  = 8;
   localparam int SY  = 2;
   localparam int CW  = 4;
   localparam int CNT_MAX = (1 << CW) - 1;

   logic          refclk;
   logic          rst_n;
   logic          pll_locked;
   logic          pll_rst;
   logic          sys_rst_n;
   logic          ready;
   logic [1:0]    state;
   logic [CW-1:0] retry_cnt;
   logic [CW-1:0] loss_cnt;

   pll_lock_supervisor #(
      .RST_CYCLES    (RST),
      .LOCK_TIMEOUT  (TO),
      .STABLE_CYCLES (ST),
      .SYNC_STAGES   (SY),
      .CNT_W         (CW)
   ) dut (
      .refclk     (refclk),
      .rst_n      (rst_n),
      .pll_locked (pll_locked),
      .pll_rst    (pll_rst),
      .sys_rst_n  (sys_rst_n),
      .ready      (ready),
      .state      (state),
      .retry_cnt  (retry_cnt),
      .loss_cnt   (loss_cnt)
   );

   initial refclk = 1'b0;
   always #5 refclk = ~refclk;

   int n_chk;
   int n_fail;

   // Behavioural model: phase + cycles spent in phase, lock seen through a delay line.
   int m_st;
   int m_age;
   int m_retry;
   int m_loss;
   bit hist[$];

   int cnt;
   int r0;
   int l0;
   int exp_loss1;
   int rise_idx[$];
   bit prev;
   bit lvl;
   int len;

   task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d at %0t", tag, act, exp, $time);
      end
   endtask

   task automatic model_reset();
      m_st    = 0;
      m_age   = 0;
      m_retry = 0;
      m_loss  = 0;
      hist    = {};
      for (int i = 0; i < SY; i++) hist.push_back(1'b0);
   endtask

   task automatic model_edge(input bit in);
      bit l;
      l = hist.pop_front();
      hist.push_back(in);
      case (m_st)
         0: begin
            m_age++;
            if (m_age == RST) begin m_st = 1; m_age = 0; end
         end
         1: begin
            if (l) begin
               m_st = 2; m_age = 0;
            end else begin
               m_age++;
               if (m_age == TO) begin
                  if (m_retry < CNT_MAX) m_retry++;
                  m_st = 0; m_age = 0;
               end
            end
         end
         2: begin
            if (!l) begin
               m_st = 1; m_age = 0;
            end else begin
               m_age++;
               if (m_age == ST) begin m_st = 3; m_age = 0; end
            end
         end
         default: begin
            if (!l) begin
               if (m_loss < CNT_MAX) m_loss++;
               m_st = 0; m_age = 0;
            end
         end
      endcase
   endtask

   task automatic check_all();
      chk("state", 32'(state), 32'(m_st));
      chk("pll_rst", 32'(pll_rst), 32'(m_st == 0));
      chk("sys_rst_n", 32'(sys_rst_n), 32'(m_st == 3));
      chk("ready", 32'(ready), 32'(m_st == 3));
      chk("retry_cnt", 32'(retry_cnt), 32'(m_retry));
`ifdef PLL_SUP_LOSS_CNT_EN
      chk("loss_cnt", 32'(loss_cnt), 32'(m_loss));
`else
      chk("loss_cnt", 32'(loss_cnt), 32'd0);
`endif
   endtask

   // One refclk cycle: input set at negedge, model steps at posedge, compare at negedge.
   task automatic cyc(input bit v);
      pll_locked = v;
      @(posedge refclk);
      model_edge(v);
      @(negedge refclk);
      check_all();
   endtask

   task automatic apply_reset();
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      check_all();
      @(negedge refclk);
      rst_n = 1'b1;
   endtask

   initial begin
      n_chk  = 0;
      n_fail = 0;
`ifdef PLL_SUP_LOSS_CNT_EN
      exp_loss1 = 1;
`else
      exp_loss1 = 0;
`endif
      rst_n      = 1'b0;
      pll_locked = 1'b0;
      model_reset();
      repeat (3) @(negedge refclk);
      check_all();
      chk("rst_pll_rst", 32'(pll_rst), 32'd1);
      rst_n = 1'b1;

      // Power-up: pll_rst pulse length, then lock raised on cycle 10.
      for (int i = 1; i <= 9; i++) begin
         cyc(1'b0);
         if (i == 3) chk("pll_rst_edge3", 32'(pll_rst), 32'd1);
         if (i == 4) chk("pll_rst_edge4", 32'(pll_rst), 32'd0);
      end
      cnt = 0;
      do begin
         cyc(1'b1);
         cnt++;
      end while (!sys_rst_n && cnt < 40);
      chk("lock_to_release", 32'(cnt), 32'd11);
      chk("ready_after_lock", 32'(ready), 32'd1);
      chk("retry_after_lock", 32'(retry_cnt), 32'd0);

      // One-cycle lock drop in RUN.
      repeat (3) cyc(1'b1);
      cnt = 1;
      cyc(1'b0);
      while (sys_rst_n && cnt < 20) begin
         cyc(1'b1);
         cnt++;
      end
      chk("loss_to_sysrst", 32'(cnt), 32'd3);
      chk("loss_state", 32'(state), 32'd0);
      chk("loss_cnt_1", 32'(loss_cnt), 32'(exp_loss1));

      // Re-lock, drop, then glitch during QUALIFY.
      repeat (20) cyc(1'b1);
      repeat (10) cyc(1'b0);
      cnt = 0;
      while (state != 2'd2 && cnt < 40) begin
         cyc(1'b1);
         cnt++;
      end
      chk("reach_qualify", 32'(state), 32'd2);
      cyc(1'b1);
      cyc(1'b1);
      r0 = m_retry;
      l0 = m_loss;
      cyc(1'b0);
      cyc(1'b0);
      cnt = 1;
      cyc(1'b1);
      chk("glitch_wait", 32'(state), 32'd1);
      while (!sys_rst_n && cnt < 40) begin
         cyc(1'b1);
         cnt++;
      end
      chk("glitch_release", 32'(cnt), 32'd11);
      chk("glitch_retry", 32'(retry_cnt), 32'(r0));
`ifdef PLL_SUP_LOSS_CNT_EN
      chk("glitch_loss", 32'(loss_cnt), 32'(l0));
`else
      chk("glitch_loss", 32'(loss_cnt), 32'd0);
`endif

      // Hold lock low: periodic PLL re-pulse and retry saturation.
      prev = pll_rst;
      for (int i = 0; i < 24 * 18; i++) begin
         cyc(1'b0);
         if (pll_rst && !prev) rise_idx.push_back(i);
         prev = pll_rst;
      end
      if (rise_idx.size() >= 3)
         chk("repulse_period", 32'(rise_idx[2] - rise_idx[1]), 32'd24);
      else
         chk("repulse_count", 32'(rise_idx.size()), 32'd3);
      chk("retry_sat", 32'(retry_cnt), 32'(CNT_MAX));

      // Asynchronous reset in the middle of QUALIFY.
      cnt = 0;
      while (state != 2'd2 && cnt < 40) begin
         cyc(1'b1);
         cnt++;
      end
      chk("reach_qualify2", 32'(state), 32'd2);
      cyc(1'b1);
      cyc(1'b1);
      #2;
      rst_n = 1'b0;
      #1;
      chk("midrst_pll_rst", 32'(pll_rst), 32'd1);
      chk("midrst_sys_rst_n", 32'(sys_rst_n), 32'd0);
      chk("midrst_ready", 32'(ready), 32'd0);
      chk("midrst_state", 32'(state), 32'd0);
      chk("midrst_retry", 32'(retry_cnt), 32'd0);
      chk("midrst_loss", 32'(loss_cnt), 32'd0);
      model_reset();
      @(negedge refclk);
      rst_n = 1'b1;

      // Random lock behaviour with occasional resets.
      for (int b = 0; b < 150; b++) begin
         lvl = ($urandom_range(0, 1) == 1);
         len = int'($urandom_range(1, 40));
         if ($urandom_range(0, 29) == 0) apply_reset();
         for (int i = 0; i < len; i++) cyc(lvl);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
